frame_tick_monitor: RTL and testbench

- Receiving end of the frame-tick strobe produced by the design's divided-clock generators (e.g. the 30 Hz frame strobe).
- Measures the clock-cycle spacing between incoming ticks and declares lock once the spacing is stable within tolerance of nominal.
- Flags ticks that arrive too early or too late.
- While locked, maintains a frame index that wraps once per second, with a second strobe, for downstream game/display logic.

---
 rtl/frame_tick_if.sv | 27 ++
 rtl/frame_tick_monitor.sv | 131 +++++++++++++
 tb/tb_frame_tick_monitor.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/frame_tick_if.sv
// Frame-tick monitor bus: the incoming tick strobe plus lock/period/error status.
// tick_in is a level sampled each clock; only its rising edge counts. All status pulses are single-cycle.
interface frame_tick_if #(
  parameter int CNT_W = 23
);
  logic             tick_in;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             locked;
  logic             err_fast;
  logic             err_slow;
  logic [5:0]       frame_index;
  logic             second_pulse;
  logic [1:0]       state;

  modport master (
    output tick_in,
    input  period_out, period_valid, locked, err_fast, err_slow,
           frame_index, second_pulse, state
  );

  modport slave (
    input  tick_in,
    output period_out, period_valid, locked, err_fast, err_slow,
           frame_index, second_pulse, state
  );
endinterface

// File: rtl/frame_tick_monitor.sv
// Measures spacing between frame-tick rising edges, declares lock when stable,
// flags early/late ticks and keeps a wrapping frame index while locked.
module frame_tick_monitor #(
  parameter int NOMINAL    = 1666667,
  parameter int TOL        = 4096,
  parameter int LOCK_COUNT = 4,
  parameter int FRAMES     = 30,
  parameter int CNT_W      = 23
) (
  input  logic      clock,
  input  logic      reset,
  frame_tick_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] MIN_P  = CNT_W'(NOMINAL - TOL);
  localparam logic [CNT_W-1:0] MAX_P  = CNT_W'(NOMINAL + TOL);
  localparam logic [GW-1:0]    LAST_G = GW'(LOCK_COUNT - 1);
  localparam logic [5:0]       LAST_F = 6'(FRAMES - 1);

  state_t           state, state_n;
  logic             tick_d;
  logic             tick_edge;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [GW-1:0]    good_cnt, good_n;
  logic [CNT_W-1:0] period_r, period_n;
  logic             pv_r, pv_n;
  logic             ef_r, ef_n;
  logic             es_r, es_n;
  logic [5:0]       fi_r, fi_n;
  logic             sp_r, sp_n;

  // tick_d resets high so a tick already high at reset release is not an edge.
  assign tick_edge = bus.tick_in & ~tick_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      tick_d   <= 1'b1;
      cnt      <= '0;
      good_cnt <= '0;
      period_r <= '0;
      pv_r     <= 1'b0;
      ef_r     <= 1'b0;
      es_r     <= 1'b0;
      fi_r     <= '0;
      sp_r     <= 1'b0;
    end else begin
      state    <= state_n;
      tick_d   <= bus.tick_in;
      cnt      <= cnt_n;
      good_cnt <= good_n;
      period_r <= period_n;
      pv_r     <= pv_n;
      ef_r     <= ef_n;
      es_r     <= es_n;
      fi_r     <= fi_n;
      sp_r     <= sp_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    good_n   = good_cnt;
    period_n = period_r;
    pv_n     = 1'b0;
    ef_n     = 1'b0;
    es_n     = 1'b0;
    fi_n     = fi_r;
    sp_n     = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (tick_edge) begin
          cnt_n   = CNT_W'(1);
          good_n  = '0;
          state_n = ACQUIRE;
        end
      end
      ACQUIRE, LOCKED: begin
        if (tick_edge) begin
          // An edge landing on the timeout cycle has cnt == MAX_P and is in tolerance.
          period_n = cnt;
          pv_n     = 1'b1;
          cnt_n    = CNT_W'(1);
          if (cnt < MIN_P) begin
            ef_n    = 1'b1;
            state_n = ACQUIRE;
            good_n  = '0;
            fi_n    = '0;
          end else if (state == ACQUIRE) begin
            if (good_cnt == LAST_G) begin
              state_n = LOCKED;
              good_n  = '0;
              fi_n    = '0;
            end else begin
              good_n = good_cnt + 1'b1;
            end
          end else if (fi_r == LAST_F) begin
            fi_n = '0;
            sp_n = 1'b1;
          end else begin
            fi_n = fi_r + 1'b1;
          end
        end else if (cnt >= MAX_P) begin
          es_n    = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
          good_n  = '0;
          fi_n    = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.period_out   = period_r;
  assign bus.period_valid = pv_r;
  assign bus.locked       = (state == LOCKED);
  assign bus.err_fast     = ef_r;
  assign bus.err_slow     = es_r;
  assign bus.frame_index  = fi_r;
  assign bus.second_pulse = sp_r;
  assign bus.state        = state;

endmodule

// File: tb/tb_frame_tick_monitor.sv
// Bench for frame_tick_monitor with NOMINAL=100, TOL=4, LOCK_COUNT=3, FRAMES=5.
module tb_frame_tick_monitor;
  localparam int CNT_W = 23;
  localparam int NV    = 26;

  typedef struct {
    int gap;      // cycles from previous rise (or from now) to this rise / timeout
    bit timeout;  // 1: hold low and expect err_slow after gap cycles
    bit pv;       // period_valid expected for this rise
    int period;
    bit ef;
    bit lk;
    int fi;
    bit sp;
  } vec_t;

  logic clock;
  logic reset;
  frame_tick_if #(.CNT_W(CNT_W)) bus ();

  frame_tick_monitor #(
    .NOMINAL(100), .TOL(4), .LOCK_COUNT(3), .FRAMES(5), .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int n_fast = 0;
  int n_slow = 0;
  int n_sec  = 0;
  logic [31:0] exp_q[$];
  vec_t vecs[NV];

  function automatic logic [31:0] pack_rec(int period, bit ef, bit lk, int fi, bit sp);
    return {CNT_W'(period), ef, lk, 6'(fi), sp};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Rise on tick_in exactly gap cycles after the previous rise; queue the expected record.
  task automatic rise_after(input int gap, input bit pv, input logic [31:0] rec);
    bus.tick_in = 1'b0;
    repeat (gap - 1) @(posedge clock);
    #1;
    bus.tick_in = 1'b1;
    if (pv) exp_q.push_back(rec);
    @(posedge clock);
    #1;
  endtask

  task automatic expect_timeout(input int gap);
    int found;
    found = -1;
    bus.tick_in = 1'b0;
    for (int k = 1; k <= gap + 20; k++) begin
      @(posedge clock);
      #1;
      if (bus.err_slow) begin
        found = k;
        break;
      end
    end
    check("timeout_cycle", 64'(found), 64'(gap));
    check("timeout_state", {62'd0, bus.state}, 64'd0);
    check("timeout_locked", {63'd0, bus.locked}, 64'd0);
  endtask

  initial begin
    vecs[0]  = '{10,  0, 0, 0,   0, 0, 0, 0};
    vecs[1]  = '{100, 0, 1, 100, 0, 0, 0, 0};
    vecs[2]  = '{100, 0, 1, 100, 0, 0, 0, 0};
    vecs[3]  = '{100, 0, 1, 100, 0, 1, 0, 0};
    vecs[4]  = '{100, 0, 1, 100, 0, 1, 1, 0};
    vecs[5]  = '{100, 0, 1, 100, 0, 1, 2, 0};
    vecs[6]  = '{100, 0, 1, 100, 0, 1, 3, 0};
    vecs[7]  = '{100, 0, 1, 100, 0, 1, 4, 0};
    vecs[8]  = '{100, 0, 1, 100, 0, 1, 0, 1};
    vecs[9]  = '{100, 0, 1, 100, 0, 1, 1, 0};
    vecs[10] = '{95,  0, 1, 95,  1, 0, 0, 0};
    vecs[11] = '{100, 0, 1, 100, 0, 0, 0, 0};
    vecs[12] = '{100, 0, 1, 100, 0, 0, 0, 0};
    vecs[13] = '{100, 0, 1, 100, 0, 1, 0, 0};
    vecs[14] = '{96,  0, 1, 96,  0, 1, 1, 0};
    vecs[15] = '{104, 0, 1, 104, 0, 1, 2, 0};
    vecs[16] = '{104, 1, 0, 0,   0, 0, 0, 0};
    vecs[17] = '{10,  0, 0, 0,   0, 0, 0, 0};
    vecs[18] = '{104, 0, 1, 104, 0, 0, 0, 0};
    vecs[19] = '{100, 0, 1, 100, 0, 0, 0, 0};
    vecs[20] = '{100, 0, 1, 100, 0, 1, 0, 0};
    vecs[21] = '{104, 0, 1, 104, 0, 1, 1, 0};
    vecs[22] = '{4,   0, 1, 4,   1, 0, 0, 0};
    vecs[23] = '{100, 0, 1, 100, 0, 0, 0, 0};
    vecs[24] = '{100, 0, 1, 100, 0, 0, 0, 0};
    vecs[25] = '{100, 0, 1, 100, 0, 1, 0, 0};

    reset = 1'b1;
    bus.tick_in = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset_outputs",
          64'({bus.period_out, bus.period_valid, bus.locked, bus.err_fast,
               bus.err_slow, bus.frame_index, bus.second_pulse, bus.state}), 64'd0);

    fork
      forever begin
        @(negedge clock);
        if (bus.period_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_period_valid", 64'(bus.period_out), 64'd0 - 64'd1);
          end else begin
            check("period_record",
                  64'({bus.period_out, bus.err_fast, bus.locked, bus.frame_index, bus.second_pulse}),
                  64'(exp_q.pop_front()));
          end
        end
        if (bus.err_fast) n_fast++;
        if (bus.err_slow) n_slow++;
        if (bus.second_pulse) n_sec++;
      end
    join_none

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].timeout)
        expect_timeout(vecs[i].gap);
      else
        rise_after(vecs[i].gap, vecs[i].pv,
                   pack_rec(vecs[i].period, vecs[i].ef, vecs[i].lk, vecs[i].fi, vecs[i].sp));
    end

    // Reset while locked with tick held high; the held level must not count as an edge.
    check("locked_before_reset", {63'd0, bus.locked}, 64'd1);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("midreset_outputs",
          64'({bus.period_out, bus.period_valid, bus.locked, bus.err_fast,
               bus.err_slow, bus.frame_index, bus.second_pulse, bus.state}), 64'd0);
    repeat (5) @(posedge clock);
    #1;
    check("held_high_state", {62'd0, bus.state}, 64'd0);
    bus.tick_in = 1'b0;
    @(posedge clock);
    #1;
    bus.tick_in = 1'b1;
    @(posedge clock);
    #1;
    check("new_edge_state", {62'd0, bus.state}, 64'd1);
    repeat (3) @(posedge clock);
    #1;

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("err_fast_count", 64'(n_fast), 64'd2);
    check("err_slow_count", 64'(n_slow), 64'd1);
    check("second_pulse_count", 64'(n_sec), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
